// File: rtl/frogger_game_fsm.sv
// Frogger game-flow sequencer: owns state, lives and score and drives play/freeze/respawn.
// Optional per-life frame timer is enabled by defining FROGGER_TIMER_EN.
module frogger_game_fsm #(
   parameter int unsigned c_START_LIVES  = 3,
   parameter int unsigned c_WIN_SCORE    = 5,
   parameter int unsigned c_GOAL_ROW     = 0,
   parameter int unsigned c_DEATH_FRAMES = 60,
   parameter int unsigned c_END_FRAMES   = 180,
   parameter int unsigned c_TIME_LIMIT   = 1800
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_VSync,
   input  logic        i_Game_Start,
   input  logic        i_Collided,
   input  logic [5:0]  i_Frogger_Y,
   output logic        o_Game_Active,
   output logic        o_Freeze,
   output logic        o_Respawn,
   output logic [1:0]  o_Lives,
   output logic [6:0]  o_Score,
   output logic [2:0]  o_State,
   output logic [11:0] o_Time_Left
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRunning  = 3'd1,
      StDying    = 3'd2,
      StP1Wins   = 3'd3,
      StGameOver = 3'd4,
      StCleanup  = 3'd5
   } state_e;

   function automatic logic [11:0] clip12(input int unsigned v);
      return (v > 32'd4095) ? 12'd4095 : v[11:0];
   endfunction

   localparam logic [11:0] DeathFrames = clip12(c_DEATH_FRAMES);
   localparam logic [11:0] EndFrames   = clip12(c_END_FRAMES);
   localparam logic [1:0]  StartLives  = 2'(c_START_LIVES);
   localparam logic [6:0]  WinScore    = 7'(c_WIN_SCORE);
   localparam logic [5:0]  GoalRow     = 6'(c_GOAL_ROW);

   state_e      state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic [6:0]  score_q, score_d;
   logic [11:0] count_q, count_d;
   logic        armed_q, armed_d;
   logic        respawn_q, respawn_d;
   logic        active_q, freeze_q;
   logic        vsync_q, start_q;
   logic        frame_tick, start_press, at_goal, timeout, hit;
   logic        load_timer;

   assign frame_tick  = i_VSync & ~vsync_q;
   assign start_press = i_Game_Start & ~start_q;
   assign at_goal     = (i_Frogger_Y == GoalRow);

`ifdef FROGGER_TIMER_EN
   localparam logic [11:0] TimeLimit = clip12(c_TIME_LIMIT);
   logic [11:0] time_q, time_d;

   assign timeout = (state_q == StRunning) && frame_tick && (time_q <= 12'd1);

   always_comb begin
      time_d = time_q;
      if (load_timer) begin
         time_d = TimeLimit;
      end else if (state_q == StRunning && frame_tick && time_q != 12'd0) begin
         time_d = time_q - 12'd1;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) time_q <= '0;
      else         time_q <= time_d;
   end

   assign o_Time_Left = time_q;
`else
   assign timeout     = 1'b0;
   assign o_Time_Left = '0;
`endif

   // A timer expiry is handled exactly like a collision, so coincident events cost one life.
   assign hit = i_Collided | timeout;

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      score_d    = score_q;
      count_d    = count_q;
      respawn_d  = 1'b0;
      load_timer = 1'b0;
      armed_d    = at_goal ? armed_q : 1'b1;
      unique case (state_q)
         StIdle: begin
            if (start_press) begin
               state_d    = StRunning;
               respawn_d  = 1'b1;
               load_timer = 1'b1;
            end
         end
         StRunning: begin
            if (hit) begin
               lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
               count_d = DeathFrames;
               state_d = StDying;
            end else if (at_goal && armed_q) begin
               score_d    = (score_q >= 7'd99) ? 7'd99 : score_q + 7'd1;
               respawn_d  = 1'b1;
               armed_d    = 1'b0;
               load_timer = 1'b1;
               if (score_d == WinScore) begin
                  state_d = StP1Wins;
                  count_d = EndFrames;
               end
            end
         end
         StDying: begin
            if (frame_tick) begin
               if (count_q <= 12'd1) begin
                  count_d = '0;
                  if (lives_q == 2'd0) begin
                     state_d = StGameOver;
                     count_d = EndFrames;
                  end else begin
                     state_d    = StRunning;
                     respawn_d  = 1'b1;
                     load_timer = 1'b1;
                  end
               end else begin
                  count_d = count_q - 12'd1;
               end
            end
         end
         StP1Wins, StGameOver: begin
            if (frame_tick && count_q != 12'd0) count_d = count_q - 12'd1;
            if (start_press || (frame_tick && count_q <= 12'd1)) state_d = StCleanup;
         end
         StCleanup: begin
            score_d   = '0;
            lives_d   = StartLives;
            count_d   = '0;
            respawn_d = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= StIdle;
         lives_q   <= StartLives;
         score_q   <= '0;
         count_q   <= '0;
         armed_q   <= 1'b0;
         respawn_q <= 1'b0;
         active_q  <= 1'b0;
         freeze_q  <= 1'b0;
         vsync_q   <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         score_q   <= score_d;
         count_q   <= count_d;
         armed_q   <= armed_d;
         respawn_q <= respawn_d;
         active_q  <= (state_d == StRunning);
         freeze_q  <= (state_d == StDying) || (state_d == StP1Wins) || (state_d == StGameOver);
         vsync_q   <= i_VSync;
         start_q   <= i_Game_Start;
      end
   end

   assign o_Game_Active = active_q;
   assign o_Freeze      = freeze_q;
   assign o_Respawn     = respawn_q;
   assign o_Lives       = lives_q;
   assign o_Score       = score_q;
   assign o_State       = state_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Directed self-checking bench for frogger_game_fsm with default parameters.
module tb_frogger_game_fsm;

   logic        clk = 1'b0;
   logic        reset, vsync, game_start, collided;
   logic [5:0]  frogger_y;
   logic        game_active, freeze, respawn;
   logic [1:0]  lives;
   logic [6:0]  score;
   logic [2:0]  state;
   logic [11:0] time_left;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses;

   always #5 clk = ~clk;

   frogger_game_fsm dut (
      .i_Clk         (clk),
      .i_Reset       (reset),
      .i_VSync       (vsync),
      .i_Game_Start  (game_start),
      .i_Collided    (collided),
      .i_Frogger_Y   (frogger_y),
      .o_Game_Active (game_active),
      .o_Freeze      (freeze),
      .o_Respawn     (respawn),
      .o_Lives       (lives),
      .o_Score       (score),
      .o_State       (state),
      .o_Time_Left   (time_left)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock; outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         vsync = 1'b1; cyc();
         vsync = 1'b0; cyc();
      end
   endtask

   initial begin
      reset = 1'b1; vsync = 1'b0; game_start = 1'b0; collided = 1'b0; frogger_y = 6'd5;
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      check("rst_state", state, 0);
      check("rst_lives", lives, 3);
      check("rst_score", score, 0);
      check("rst_active", game_active, 0);
      check("rst_freeze", freeze, 0);
      check("rst_respawn", respawn, 0);
`ifndef FROGGER_TIMER_EN
      check("time_left_off", time_left, 0);
`endif
      frames(10);
      check("idle_state", state, 0);
      check("idle_lives", lives, 3);

      // Held start button: one entry, one respawn pulse.
      game_start = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (respawn) pulses++;
      end
      game_start = 1'b0;
      check("start_respawns", pulses, 1);
      check("start_state", state, 1);
      check("start_active", game_active, 1);

      // Collision held 3 cycles costs one life.
      collided = 1'b1;
      cyc();
      check("col_state", state, 2);
      check("col_lives", lives, 2);
      check("col_freeze", freeze, 1);
      check("col_active", game_active, 0);
      cyc(); cyc();
      collided = 1'b0;
      check("col_held_lives", lives, 2);
      frames(59);
      check("dying_59", state, 2);
      vsync = 1'b1; cyc();
      check("dying_60_state", state, 1);
      check("dying_60_respawn", respawn, 1);
      vsync = 1'b0; cyc();
      check("respawn_one_cycle", respawn, 0);
      check("rerun_freeze", freeze, 0);

      // Goal held: scores once.
      frogger_y = 6'd0;
      cyc();
      check("goal_score", score, 1);
      check("goal_respawn", respawn, 1);
      for (int i = 0; i < 19; i++) cyc();
      check("goal_held_score", score, 1);
      frogger_y = 6'd5; cyc();
      for (int i = 0; i < 4; i++) begin
         frogger_y = 6'd0; cyc();
         frogger_y = 6'd5; cyc();
      end
      check("win_score", score, 5);
      check("win_state", state, 3);
      check("win_freeze", freeze, 1);
      frames(3);
      check("win_hold", state, 3);
      game_start = 1'b1; cyc();
      check("win_start_cleanup", state, 5);
      game_start = 1'b0; cyc();
      check("cleanup_idle", state, 0);
      check("cleanup_lives", lives, 3);
      check("cleanup_score", score, 0);
      check("cleanup_respawn", respawn, 1);

      // Collision and goal together: collision wins.
      game_start = 1'b1; cyc();
      game_start = 1'b0;
      check("restart_state", state, 1);
      collided = 1'b1; frogger_y = 6'd0; cyc();
      collided = 1'b0; frogger_y = 6'd5;
      check("both_score", score, 0);
      check("both_lives", lives, 2);
      check("both_state", state, 2);

      // Drain remaining lives into GAME_OVER.
      frames(60);
      check("life2_run", state, 1);
      collided = 1'b1; cyc(); collided = 1'b0;
      check("life1_lives", lives, 1);
      frames(60);
      collided = 1'b1; cyc(); collided = 1'b0;
      check("life0_lives", lives, 0);
      frames(59);
      check("life0_dying", state, 2);
      frames(1);
      check("gameover_state", state, 4);
      check("gameover_freeze", freeze, 1);
      check("gameover_respawn", respawn, 0);
      frames(179);
      check("gameover_hold", state, 4);
      vsync = 1'b1; cyc();
      check("gameover_cleanup", state, 5);
      vsync = 1'b0; cyc();
      check("end_idle", state, 0);
      check("end_lives", lives, 3);
      check("end_score", score, 0);
      check("end_freeze", freeze, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/frogger_game_fsm.md
Name: frogger_game_fsm

Overview:
Game-flow sequencer for the Frogger datapath. It owns the game state, lives and score, and drives the play/freeze/respawn controls consumed by frogger_ctrl, the car/log controllers and score_control. Inputs are the start button, the collision flag from frogger_collisions, Frogger's tile row and the VGA vertical sync, which serves as the frame timebase. It replaces the unused state enumeration and the tied-high game-active wire in the top level.

Parameters:
c_START_LIVES, 3, lives loaded at reset and at CLEANUP (1..3)
c_WIN_SCORE, 5, score that ends the game as a win (1..99)
c_GOAL_ROW, 0, tile row that counts as reaching a lily pad
c_DEATH_FRAMES, 60, frames frozen after a collision
c_END_FRAMES, 180, frames shown in P1_WINS or GAME_OVER before auto-cleanup
c_TIME_LIMIT, 1800, frames allowed per life (used only with FROGGER_TIMER_EN)

Ports:
i_Clk  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous reset, active-high
i_VSync  in  1  vertical sync from Sync_To_Count; a rising edge is one frame tick
i_Game_Start  in  1  start button, already debounced, level
i_Collided  in  1  collision flag from frogger_collisions, level
i_Frogger_Y  in  6  Frogger tile row
o_Game_Active  out  1  high only in RUNNING
o_Freeze  out  1  high in DYING, P1_WINS, GAME_OVER; movers hold position
o_Respawn  out  1  one-cycle pulse: return Frogger to its start tile
o_Lives  out  2  remaining lives
o_Score  out  7  binary score, 0..99
o_State  out  3  current state encoding
o_Time_Left  out  12  frames left in the current life; 0 when the feature is off

Behaviour:
- All outputs are registered. A state or counter change appears 1 cycle after the qualifying input is sampled.
- Reset applied in any state, mid-count included, forces:
  - state IDLE, lives = c_START_LIVES, score 0, frame counter 0
  - o_Game_Active = 0, o_Freeze = 0, o_Respawn = 0, edge registers cleared
- Edge detection:
  - Frame tick = i_VSync high now AND low in the previous cycle (one flop).
  - Start press = rising edge of i_Game_Start (one flop). A held button is one press.
- State encodings: IDLE=0, RUNNING=1, DYING=2, P1_WINS=3, GAME_OVER=4, CLEANUP=5. Encodings 6 and 7 go to IDLE on the next cycle.
- IDLE: start press -> RUNNING, with o_Respawn pulsed in the same transition cycle.
- RUNNING, priorities in order:
  - Collision (i_Collided=1): lives -= 1 (saturating at 0), counter = c_DEATH_FRAMES, -> DYING.
  - Else goal (i_Frogger_Y == c_GOAL_ROW): score += 1 (saturating at 99), o_Respawn pulse.
    - If the new score == c_WIN_SCORE: -> P1_WINS, counter = c_END_FRAMES.
    - Otherwise stay in RUNNING.
  - Goal credit is accepted only once per arrival. Goal is re-armed only after i_Frogger_Y != c_GOAL_ROW has been seen; this prevents double counting while the respawn propagates.
  - Collision and goal in the same cycle: the collision wins and the score is unchanged.
- DYING:
  - Counter decrements on each frame tick. i_Collided is ignored.
  - At the tick where the counter reaches 0:
    - lives == 0 -> GAME_OVER, counter = c_END_FRAMES
    - otherwise -> RUNNING with an o_Respawn pulse
- P1_WINS / GAME_OVER:
  - Counter decrements on frame ticks.
  - Counter reaching 0 or a start press -> CLEANUP.
- CLEANUP, exactly one cycle: score = 0, lives = c_START_LIVES, o_Respawn pulse, -> IDLE.
- Counter width is 12 bits; parameters above 4095 are clipped to 4095.

Optional Feature:
FROGGER_TIMER_EN
- Defined:
  - o_Time_Left loads c_TIME_LIMIT on entering RUNNING from IDLE or DYING, and on every goal.
  - It decrements on frame ticks while in RUNNING and holds in all other states.
  - When it reaches 0 in RUNNING, the block behaves exactly as a collision: lives -= 1, -> DYING.
  - If a collision and the timeout coincide, only one life is lost.
- Undefined: o_Time_Left is tied to 0; no timer logic is generated.

Test Plan:
- Reset, then 10 frames idle -> state 0, lives 3, score 0, active 0. Start held 5 cycles -> one RUNNING entry and one respawn pulse.
- RUNNING, i_Collided high for 3 cycles -> lives 2, state DYING, freeze 1. After exactly 60 frame ticks -> RUNNING with a respawn pulse.
- Three collisions, each followed by 60 frames -> lives 0, state GAME_OVER. After 180 ticks -> CLEANUP for 1 cycle, then IDLE with lives 3, score 0.
- i_Frogger_Y=0 held 20 cycles -> score increases by exactly 1. Y toggled 0/5 five times -> score 5, state P1_WINS. A start press during the hold -> CLEANUP on the next cycle.
- i_Collided=1 and i_Frogger_Y=0 in the same cycle -> score unchanged, lives decremented, DYING.
- With FROGGER_TIMER_EN and c_TIME_LIMIT=4: 4 frame ticks with no input -> lives 2, DYING. o_Time_Left reloads to 4 on return to RUNNING.
